store_buffer: RTL and testbench

- Receiving end of the store reservation station's issue interface.
- Captures each resolved store (value, effective address, ROB tag) when the station pulses its store-enable.
- Reports address/data readiness to the ROB and holds the store until the ROB commits that tag.
- Drains committed stores to data memory in program order over a req/ack handshake, and forwards buffered data to loads on an address match.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/store_buffer_if.sv | 45 ++++
 rtl/store_fwd_match.sv | 31 +++
 rtl/store_buffer.sv | 167 ++++++++++++++++
 tb/tb_store_buffer.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: ROB tag format and store buffer encodings.
// Imported by the store buffer, its interface and the forwarding search.
package cpu_pkg;

    localparam int TAG_W = 6;
    localparam logic [TAG_W-1:0] INVALID_TAG = 6'b010000;

    typedef enum logic [1:0] {
        EMPTY     = 2'b00,
        PENDING   = 2'b01,
        COMMITTED = 2'b10
    } ent_state_e;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } drain_state_e;

endpackage

// File: rtl/store_buffer_if.sv
// Store buffer bundle: issue, ROB completion/commit, memory write and
// load-forwarding probe. slave is the buffer side, master the environment.
interface store_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = cpu_pkg::TAG_W
);
    logic                     st_valid;
    logic [DATA_W-1:0]        st_data;
    logic [DATA_W-1:0]        st_addr;
    logic [TAG_W-1:0]         st_rob;
    logic                     full;
    logic                     overflow;
    logic                     done_valid;
    logic [TAG_W-1:0]         done_rob;
    logic                     commit_valid;
    logic [TAG_W-1:0]         commit_rob;
    logic                     flush;
    logic                     mem_req;
    logic [DATA_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     mem_ack;
    logic [DATA_W-1:0]        ld_addr;
    logic                     ld_hit;
    logic [DATA_W-1:0]        ld_data;
    logic [$clog2(DEPTH):0]   count;

    modport slave (
        input  st_valid, st_data, st_addr, st_rob,
        input  commit_valid, commit_rob, flush,
        input  mem_ack, ld_addr,
        output full, overflow, done_valid, done_rob,
        output mem_req, mem_addr, mem_wdata,
        output ld_hit, ld_data, count
    );

    modport master (
        output st_valid, st_data, st_addr, st_rob,
        output commit_valid, commit_rob, flush,
        output mem_ack, ld_addr,
        input  full, overflow, done_valid, done_rob,
        input  mem_req, mem_addr, mem_wdata,
        input  ld_hit, ld_data, count
    );
endinterface

// File: rtl/store_fwd_match.sv
// Youngest-match search for load forwarding. Live entries are contiguous
// from head, so walking head upward lets the last match win.
module store_fwd_match #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0][DATA_W-1:0] addr,
    input  logic [DEPTH-1:0][DATA_W-1:0] data,
    input  logic [$clog2(DEPTH)-1:0]     head,
    input  logic [DATA_W-1:0]            ld_addr,
    output logic                         hit,
    output logic [DATA_W-1:0]            hit_data
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (valid[idx] && addr[idx] == ld_addr) begin
                hit      = 1'b1;
                hit_data = data[idx];
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// Store buffer: holds resolved stores until ROB commit, drains them to
// memory in order over req/ack, and forwards buffered data to loads.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = cpu_pkg::TAG_W,
    parameter logic [TAG_W-1:0] INVALID_TAG = cpu_pkg::INVALID_TAG
) (
    input logic           clock,
    input logic           reset,
    store_buffer_if.slave bus
);
    import cpu_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ent_state_e                   st_q [DEPTH];
    ent_state_e                   st_d [DEPTH];
    logic [DEPTH-1:0][DATA_W-1:0] addr_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [DEPTH-1:0][TAG_W-1:0]  rob_q;
    logic [DEPTH-1:0]             live;
    logic [PW-1:0]                head_q;
    logic [PW-1:0]                tail_q;
    logic [PW-1:0]                tail_d;
    logic [CW-1:0]                count_q;
    logic [CW-1:0]                count_d;
    logic [CW-1:0]                n_comm;
    drain_state_e                 drain_q;
    drain_state_e                 drain_d;
    logic                         load;
    logic                         full;
    logic                         accept;
    logic                         pop;
    logic                         commit_ok;
    logic                         overflow_q;
    logic                         done_valid_q;
    logic [TAG_W-1:0]             done_rob_q;
    logic [DATA_W-1:0]            mem_addr_q;
    logic [DATA_W-1:0]            mem_wdata_q;

    assign full      = (count_q == CW'(DEPTH));
    assign accept    = bus.st_valid && !full && !bus.flush;
    assign pop       = (drain_q == WRITE) && bus.mem_ack;
    assign commit_ok = bus.commit_valid &&
                       (bus.commit_rob != INVALID_TAG);

    // Commit lands before flush, so a same-cycle retire survives.
    always_comb begin
        st_d   = st_q;
        n_comm = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (commit_ok && st_q[i] == PENDING &&
                rob_q[i] == bus.commit_rob)
                st_d[i] = COMMITTED;
            if (bus.flush && st_d[i] == PENDING)
                st_d[i] = EMPTY;
            if (st_d[i] == COMMITTED)
                n_comm = n_comm + CW'(1);
        end
        if (pop)
            st_d[head_q] = EMPTY;
        if (accept)
            st_d[tail_q] = PENDING;
    end

    always_comb begin
        if (bus.flush) begin
            tail_d  = head_q + n_comm[PW-1:0];
            count_d = n_comm - CW'(pop);
        end else begin
            tail_d  = tail_q + PW'(accept);
            count_d = count_q + CW'(accept) - CW'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                st_q[i] <= EMPTY;
            addr_q       <= '0;
            data_q       <= '0;
            rob_q        <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            done_valid_q <= 1'b0;
            done_rob_q   <= INVALID_TAG;
        end else begin
            st_q    <= st_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (accept) begin
                addr_q[tail_q] <= bus.st_addr;
                data_q[tail_q] <= bus.st_data;
                rob_q[tail_q]  <= bus.st_rob;
            end
            if (pop)
                head_q <= head_q + PW'(1);
            if (bus.st_valid && full && !bus.flush)
                overflow_q <= 1'b1;
            done_valid_q <= accept;
            done_rob_q   <= accept ? bus.st_rob : INVALID_TAG;
        end
    end

    always_comb begin
        drain_d = drain_q;
        load    = 1'b0;
        unique case (drain_q)
            IDLE: begin
                if (st_q[head_q] == COMMITTED) begin
                    drain_d = WRITE;
                    load    = 1'b1;
                end
            end
            WRITE: begin
                if (bus.mem_ack)
                    drain_d = IDLE;
            end
            default: drain_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drain_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            drain_q <= drain_d;
            if (load) begin
                mem_addr_q  <= addr_q[head_q];
                mem_wdata_q <= data_q[head_q];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            live[i] = (st_q[i] != EMPTY);
    end

    store_fwd_match #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fwd (
        .valid    (live),
        .addr     (addr_q),
        .data     (data_q),
        .head     (head_q),
        .ld_addr  (bus.ld_addr),
        .hit      (bus.ld_hit),
        .hit_data (bus.ld_data)
    );

    assign bus.full       = full;
    assign bus.overflow   = overflow_q;
    assign bus.done_valid = done_valid_q;
    assign bus.done_rob   = done_rob_q;
    assign bus.mem_req    = (drain_q == WRITE);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.count      = count_q;
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, random traffic.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int TW    = 6;
    localparam logic [5:0] INV = 6'b010000;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    store_buffer_if #(.DEPTH(DEPTH), .DATA_W(DW), .TAG_W(TW)) bus ();

    store_buffer #(
        .DEPTH(DEPTH), .DATA_W(DW), .TAG_W(TW), .INVALID_TAG(INV)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer as an ordered list, oldest first.
    typedef struct {
        logic [31:0] d;
        logic [31:0] a;
        logic [5:0]  r;
        bit          c;
    } ment_t;

    ment_t       mq[$];
    bit          m_wr  = 0;
    bit          m_ovf = 0;
    bit          m_dv  = 0;
    logic [5:0]  m_dr  = INV;
    logic [31:0] m_ma  = '0;
    logic [31:0] m_md  = '0;

    always @(posedge clock or negedge reset) begin : model
        int  n;
        bit  acc;
        bit  pop;
        bit  start;
        if (!reset) begin
            mq.delete();
            m_wr = 0; m_ovf = 0; m_dv = 0; m_dr = INV;
            m_ma = '0; m_md = '0;
        end else begin
            n     = mq.size();
            acc   = bus.st_valid && n < DEPTH && !bus.flush;
            pop   = m_wr && bus.mem_ack;
            start = !m_wr && n > 0 && mq[0].c;
            if (bus.st_valid && n == DEPTH && !bus.flush) m_ovf = 1;
            if (start) begin
                m_ma = mq[0].a;
                m_md = mq[0].d;
            end
            if (bus.commit_valid && bus.commit_rob != INV)
                for (int i = 0; i < mq.size(); i++)
                    if (!mq[i].c && mq[i].r == bus.commit_rob) mq[i].c = 1;
            if (bus.flush)
                for (int i = mq.size() - 1; i >= 0; i--)
                    if (!mq[i].c) mq.delete(i);
            if (pop) void'(mq.pop_front());
            if (acc)
                mq.push_back('{d: bus.st_data, a: bus.st_addr,
                               r: bus.st_rob, c: 1'b0});
            m_dv = acc;
            if (acc) m_dr = bus.st_rob;
            if (start) m_wr = 1;
            else if (pop) m_wr = 0;
        end
    end

    always @(negedge clock) begin : cmp
        bit          eh;
        logic [31:0] ed;
        eh = 0;
        ed = '0;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].a == bus.ld_addr) begin
                eh = 1;
                ed = mq[i].d;
            end
        check("count", bus.count, mq.size());
        check("full", bus.full, mq.size() == DEPTH);
        check("overflow", bus.overflow, m_ovf);
        check("done_valid", bus.done_valid, m_dv);
        if (m_dv) check("done_rob", bus.done_rob, m_dr);
        check("mem_req", bus.mem_req, m_wr);
        if (m_wr) begin
            check("mem_addr", bus.mem_addr, m_ma);
            check("mem_wdata", bus.mem_wdata, m_md);
        end
        check("ld_hit", bus.ld_hit, eh);
        check("ld_data", bus.ld_data, ed);
    end

    logic [63:0] wlog[$];
    always @(posedge clock)
        if (reset && bus.mem_req && bus.mem_ack)
            wlog.push_back({bus.mem_addr, bus.mem_wdata});

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.st_valid = 0; bus.st_data = '0; bus.st_addr = '0;
        bus.st_rob = '0; bus.commit_valid = 0; bus.commit_rob = '0;
        bus.flush = 0; bus.mem_ack = 0; bus.ld_addr = '0;
    endtask

    task automatic issue(input logic [5:0] t, input logic [31:0] a,
                         input logic [31:0] d);
        bus.st_valid = 1; bus.st_rob = t;
        bus.st_addr = a; bus.st_data = d;
        tick();
        bus.st_valid = 0;
    endtask

    task automatic do_commit(input logic [5:0] t);
        bus.commit_valid = 1; bus.commit_rob = t;
        tick();
        bus.commit_valid = 0;
    endtask

    task automatic do_flush();
        bus.flush = 1;
        tick();
        bus.flush = 0;
    endtask

    task automatic wait_empty(input string name, input int max);
        int k;
        k = 0;
        while (bus.count != 0 && k < max) begin
            tick();
            k++;
        end
        check(name, bus.count, 0);
    endtask

    function automatic bit in_q(input logic [5:0] t);
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].r == t) return 1;
        return 0;
    endfunction

    logic [31:0] t2_a [6];
    logic [31:0] t2_d [6];
    logic [5:0]  next_tag;
    logic [5:0]  bog;
    int          base;
    int          pend;
    int          r;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        t2_a = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h210, 32'h214};
        t2_d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hB0, 32'hB1};
        idle();
        repeat (2) @(posedge clock);
        #1;
        check("rst_count", bus.count, 0);
        check("rst_full", bus.full, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_done_valid", bus.done_valid, 0);
        check("rst_done_rob", bus.done_rob, INV);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_ld_hit", bus.ld_hit, 0);
        check("rst_ld_data", bus.ld_data, 0);
        reset = 1;
        tick();

        // single store through commit and a slow memory ack
        issue(6'd5, 32'h100, 32'hDEADBEEF);
        check("t1_done_valid", bus.done_valid, 1);
        check("t1_done_rob", bus.done_rob, 5);
        check("t1_count", bus.count, 1);
        do_commit(6'd5);
        tick();
        check("t1_mem_req", bus.mem_req, 1);
        check("t1_mem_addr", bus.mem_addr, 32'h100);
        check("t1_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        tick();
        tick();
        check("t1_req_held", bus.mem_req, 1);
        check("t1_addr_held", bus.mem_addr, 32'h100);
        bus.mem_ack = 1;
        tick();
        bus.mem_ack = 0;
        check("t1_count0", bus.count, 0);
        check("t1_req_low", bus.mem_req, 0);

        // fill, overflow, in-order drain and refill across the wrap
        base = wlog.size();
        for (int i = 0; i < 4; i++)
            issue(6'(i + 1), t2_a[i], t2_d[i]);
        check("t2_full", bus.full, 1);
        check("t2_count4", bus.count, 4);
        issue(6'd7, 32'h300, 32'h77);
        check("t2_overflow", bus.overflow, 1);
        check("t2_no_done", bus.done_valid, 0);
        check("t2_count_kept", bus.count, 4);
        bus.mem_ack = 1;
        for (int i = 1; i <= 4; i++)
            do_commit(6'(i));
        wait_empty("t2_drain", 40);
        bus.mem_ack = 0;
        issue(6'd20, t2_a[4], t2_d[4]);
        issue(6'd21, t2_a[5], t2_d[5]);
        do_commit(6'd20);
        do_commit(6'd21);
        bus.mem_ack = 1;
        wait_empty("t2_refill_drain", 40);
        bus.mem_ack = 0;
        check("t2_nwrites", wlog.size() - base, 6);
        for (int i = 0; i < 6 && base + i < wlog.size(); i++) begin
            check("t2_wr_addr", wlog[base + i][63:32], t2_a[i]);
            check("t2_wr_data", wlog[base + i][31:0], t2_d[i]);
        end

        // flush drops uncommitted stores, committed one still drains
        issue(6'd2, 32'h400, 32'hC2);
        issue(6'd3, 32'h404, 32'hC3);
        issue(6'd4, 32'h408, 32'hC4);
        check("t3_count3", bus.count, 3);
        do_commit(6'd2);
        do_flush();
        check("t3_count1", bus.count, 1);
        bus.ld_addr = 32'h404;
        #1;
        check("t3_flushed_miss", bus.ld_hit, 0);
        bus.mem_ack = 1;
        wait_empty("t3_drain", 20);
        bus.mem_ack = 0;
        if (wlog.size() > 0) begin
            check("t3_wr_addr", wlog[wlog.size() - 1][63:32], 32'h400);
            check("t3_wr_data", wlog[wlog.size() - 1][31:0], 32'hC2);
        end else begin
            check("t3_wr_seen", wlog.size(), 1);
        end

        // forwarding picks the youngest of two stores to one address
        issue(6'd10, 32'h40, 32'h11);
        issue(6'd11, 32'h40, 32'h22);
        bus.ld_addr = 32'h40;
        #1;
        check("t4_hit", bus.ld_hit, 1);
        check("t4_data", bus.ld_data, 32'h22);
        bus.ld_addr = 32'h44;
        #1;
        check("t4_miss", bus.ld_hit, 0);
        check("t4_miss_data", bus.ld_data, 0);
        do_flush();
        check("t4_count0", bus.count, 0);

        // accept and pop in the same cycle
        issue(6'd8, 32'h300, 32'h88);
        do_commit(6'd8);
        tick();
        check("t6_req", bus.mem_req, 1);
        check("t6_count_before", bus.count, 1);
        bus.mem_ack = 1;
        bus.st_valid = 1; bus.st_rob = 6'd9;
        bus.st_addr = 32'h304; bus.st_data = 32'h99;
        tick();
        bus.st_valid = 0;
        bus.mem_ack = 0;
        check("t6_count_same", bus.count, 1);
        check("t6_done_valid", bus.done_valid, 1);
        check("t6_done_rob", bus.done_rob, 9);

        // reset while a write is outstanding
        bus.ld_addr = 32'h304;
        do_commit(6'd9);
        tick();
        check("t5_req_before", bus.mem_req, 1);
        #2;
        reset = 0;
        #1;
        check("t5_req", bus.mem_req, 0);
        check("t5_count", bus.count, 0);
        check("t5_overflow", bus.overflow, 0);
        check("t5_full", bus.full, 0);
        check("t5_done_rob", bus.done_rob, INV);
        check("t5_mem_addr", bus.mem_addr, 0);
        check("t5_mem_wdata", bus.mem_wdata, 0);
        check("t5_ld_hit", bus.ld_hit, 0);
        check("t5_ld_data", bus.ld_data, 0);
        tick();
        base = wlog.size();
        bus.mem_ack = 1;
        reset = 1;
        repeat (3) tick();
        check("t5_late_ack_req", bus.mem_req, 0);
        check("t5_late_ack_count", bus.count, 0);
        check("t5_late_ack_log", wlog.size() - base, 0);
        bus.mem_ack = 0;

        // random traffic against the model
        next_tag = 6'd30;
        for (int c = 0; c < 3000; c++) begin
            idle();
            if ($urandom_range(0, 99) < 45 && !in_q(next_tag)) begin
                bus.st_valid = 1;
                bus.st_rob   = next_tag;
                bus.st_data  = $urandom;
                bus.st_addr  = 32'($urandom_range(0, 7)) << 2;
                next_tag = next_tag + 6'd1;
                if (next_tag == INV) next_tag = next_tag + 6'd1;
            end
            pend = -1;
            for (int i = mq.size() - 1; i >= 0; i--)
                if (!mq[i].c) pend = i;
            r = int'($urandom_range(0, 99));
            if (r < 35 && pend >= 0) begin
                bus.commit_valid = 1;
                bus.commit_rob   = mq[pend].r;
            end else if (r >= 35 && r < 42) begin
                bog = 6'($urandom);
                if (in_q(bog)) bog = INV;
                bus.commit_valid = 1;
                bus.commit_rob   = bog;
            end
            bus.flush   = ($urandom_range(0, 99) < 3);
            bus.mem_ack = 1'($urandom_range(0, 1));
            bus.ld_addr = 32'($urandom_range(0, 8)) << 2;
            tick();
        end
        idle();
        do_flush();
        bus.mem_ack = 1;
        wait_empty("final_drain", 40);
        bus.mem_ack = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
